// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson phase decoder: FSM state type,
// default ring width and a combinational code-to-phase decoder.
package johnson_pkg;

    localparam int JOHNSON_W_DEFAULT = 5;

    // Widest ring the decode helper handles; callers zero-extend into it.
    localparam int JOHNSON_W_MAX = 16;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        ERROR    = 2'd3
    } jpd_state_t;

    typedef struct packed {
        logic       legal;
        logic [7:0] idx;
    } jpd_decode_t;

    // Twisted-ring code of phase k on a w-bit register: k ones filling in
    // from the LSB for k <= w, then zeros filling in from the LSB.
    function automatic logic [JOHNSON_W_MAX-1:0] johnson_code(input int k, input int w);
        logic [JOHNSON_W_MAX-1:0] c;
        c = '0;
        for (int i = 0; i < JOHNSON_W_MAX; i++) begin
            if (i >= w) begin
                c[i] = 1'b0;
            end else if (k <= w) begin
                c[i] = (i < k);
            end else begin
                c[i] = (i >= (k - w));
            end
        end
        return c;
    endfunction

    // Match the code against every legal phase; no match means illegal.
    function automatic jpd_decode_t johnson_decode(input logic [JOHNSON_W_MAX-1:0] code,
                                                   input int w);
        jpd_decode_t d;
        d.legal = 1'b0;
        d.idx   = 8'd0;
        for (int k = 0; k < 2 * JOHNSON_W_MAX; k++) begin
            if ((k < 2 * w) && (code == johnson_code(k, w))) begin
                d.legal = 1'b1;
                d.idx   = 8'(k);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and phase-index decode of one Johnson code.
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter  int W  = JOHNSON_W_DEFAULT,
    localparam int IW = $clog2(2 * W)
) (
    input  logic [W-1:0]  code,
    output logic          legal,
    output logic [IW-1:0] idx
);

    logic [JOHNSON_W_MAX-1:0] code_ext_s;
    jpd_decode_t              dec_s;

    // Zero-extend the sampled code into the decoder's fixed width
    always_comb begin
        code_ext_s         = '0;
        code_ext_s[W-1:0]  = code;
    end

    assign dec_s = johnson_decode(code_ext_s, W);

    // The range guard rejects any decode index that could not fit 0..2W-1
    assign legal = dec_s.legal && (dec_s.idx < 8'(2 * W));
    assign idx   = dec_s.idx[IW-1:0];

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder: registers the decoded phase of the counter's
// twisted-ring code, checks step continuity, tracks lock and requests a
// counter resync on lock loss.
// Optional feature macro: JOHNSON_DEC_ERR_COUNT_EN (saturating error counter).
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter  int W        = JOHNSON_W_DEFAULT,
    parameter  int LOCK_CNT = 4,
    localparam int IW       = $clog2(2 * W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    q_in,
    input  logic            q_valid,
    output logic [IW-1:0]   phase_idx,
    output logic [2*W-1:0]  phase_onehot,
    output logic            phase_valid,
    output logic            illegal,
    output logic            step_err,
    output logic            locked,
    output logic            resync_req,
    output logic [7:0]      err_cnt
);

    localparam int            NPH      = 2 * W;
    localparam logic [IW-1:0] LAST_IDX = IW'(NPH - 1);
    localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);

    logic           legal_s;
    logic [IW-1:0]  k_s;
    logic [IW-1:0]  next_s;
    logic           hold_s;
    logic           adv_s;
    logic           bad_step_s;
    logic           illegal_s;
    logic [3:0]     good_inc_s;
    logic [NPH-1:0] onehot_s;

    jpd_state_t     state_r;
    logic [3:0]     good_cnt_r;
    logic [IW-1:0]  prev_r;
    logic [IW-1:0]  phase_idx_r;
    logic [NPH-1:0] phase_onehot_r;
    logic           phase_valid_r;
    logic           illegal_r;
    logic           step_err_r;
    logic           locked_r;
    logic           resync_r;

    johnson_code_check #(.W(W)) u_check (
        .code  (q_in),
        .legal (legal_s),
        .idx   (k_s)
    );

    // Classify the sample against the last legal phase (hold, advance, bad)
    always_comb begin
        if (prev_r == LAST_IDX) begin
            next_s = '0;
        end else begin
            next_s = prev_r + IW'(1);
        end
        hold_s     = legal_s && (k_s == prev_r);
        adv_s      = legal_s && (k_s == next_s);
        bad_step_s = legal_s && !(hold_s || adv_s);
        illegal_s  = !legal_s;
        good_inc_s = good_cnt_r + 4'd1;
    end

    // One-hot image of the decoded phase, empty for an illegal code
    always_comb begin
        onehot_s = '0;
        for (int i = 0; i < NPH; i++) begin
            onehot_s[i] = legal_s && (k_s == IW'(i));
        end
    end

    // Output registers, phase history and the lock FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= UNLOCKED;
            good_cnt_r     <= 4'd0;
            prev_r         <= '0;
            phase_idx_r    <= '0;
            phase_onehot_r <= '0;
            phase_valid_r  <= 1'b0;
            illegal_r      <= 1'b0;
            step_err_r     <= 1'b0;
            locked_r       <= 1'b0;
            resync_r       <= 1'b0;
        end else if (!q_valid) begin
            // Everything holds; only the event pulses drop.
            illegal_r  <= 1'b0;
            step_err_r <= 1'b0;
            resync_r   <= 1'b0;
        end else begin
            illegal_r      <= illegal_s;
            step_err_r     <= bad_step_s;
            resync_r       <= 1'b0;
            phase_onehot_r <= onehot_s;
            phase_valid_r  <= legal_s;
            if (legal_s) begin
                phase_idx_r <= k_s;
                prev_r      <= k_s;
            end
            case (state_r)
                UNLOCKED: begin
                    if (legal_s) begin
                        state_r    <= ACQUIRE;
                        good_cnt_r <= 4'd0;
                    end
                end
                ACQUIRE: begin
                    if (illegal_s || bad_step_s) begin
                        state_r    <= UNLOCKED;
                        good_cnt_r <= 4'd0;
                    end else if (adv_s) begin
                        // A hold neither advances nor clears the count.
                        good_cnt_r <= good_inc_s;
                        if (good_inc_s == LOCK_TGT) begin
                            state_r  <= LOCKED;
                            locked_r <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (illegal_s || bad_step_s) begin
                        state_r  <= ERROR;
                        locked_r <= 1'b0;
                        resync_r <= 1'b1;
                    end
                end
                ERROR: begin
                    // The counter is being reset; the code is ignored here.
                    state_r    <= UNLOCKED;
                    good_cnt_r <= 4'd0;
                end
                default: begin
                    state_r    <= UNLOCKED;
                    good_cnt_r <= 4'd0;
                    locked_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef JOHNSON_DEC_ERR_COUNT_EN
    logic       err_event_s;
    logic [7:0] err_cnt_r;

    assign err_event_s = q_valid && (illegal_s || bad_step_s);

    // Saturating count of illegal-code and bad-step events
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (err_event_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = 8'd0;
`endif

    assign phase_idx    = phase_idx_r;
    assign phase_onehot = phase_onehot_r;
    assign phase_valid  = phase_valid_r;
    assign illegal      = illegal_r;
    assign step_err     = step_err_r;
    assign locked       = locked_r;
    assign resync_req   = resync_r;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder (W=5, LOCK_CNT=4).
module tb_johnson_phase_decoder;

    localparam int W        = 5;
    localparam int N        = 2 * W;
    localparam int LOCK_CNT = 4;
    localparam int IW       = $clog2(N);

    localparam int S_UNL = 0;
    localparam int S_ACQ = 1;
    localparam int S_LCK = 2;
    localparam int S_ERR = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          q_valid = 1'b0;
    logic [W-1:0]  q_in = '0;
    logic [IW-1:0] phase_idx;
    logic [N-1:0]  phase_onehot;
    logic          phase_valid;
    logic          illegal;
    logic          step_err;
    logic          locked;
    logic          resync_req;
    logic [7:0]    err_cnt;

    int errors = 0;
    int checks = 0;

    int m_idx, m_valid, m_ill, m_serr, m_resync, m_err, m_state, m_good, m_prev;

    johnson_phase_decoder #(.W(W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk          (clk),
        .rst          (rst),
        .q_in         (q_in),
        .q_valid      (q_valid),
        .phase_idx    (phase_idx),
        .phase_onehot (phase_onehot),
        .phase_valid  (phase_valid),
        .illegal      (illegal),
        .step_err     (step_err),
        .locked       (locked),
        .resync_req   (resync_req),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Legal code of phase k straight from the arithmetic definition
    function automatic int ref_code(input int k);
        if (k <= W) return (1 << k) - 1;
        return ((1 << W) - 1) & ~((1 << (k - W)) - 1);
    endfunction

    function automatic int ref_lookup(input int q);
        for (int k = 0; k < N; k++) begin
            if (ref_code(k) == q) return k;
        end
        return -1;
    endfunction

    function automatic int exp_err();
`ifdef JOHNSON_DEC_ERR_COUNT_EN
        return m_err;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_step(input int q, input bit v, input bit r);
        int k;
        bit good, adv;
        if (r) begin
            m_idx = 0; m_valid = 0; m_ill = 0; m_serr = 0; m_resync = 0;
            m_err = 0; m_state = S_UNL; m_good = 0; m_prev = 0;
        end else if (!v) begin
            m_ill = 0; m_serr = 0; m_resync = 0;
        end else begin
            k = ref_lookup(q);
            m_resync = 0;
            if (k < 0) begin
                m_ill = 1; m_serr = 0; m_valid = 0;
                if (m_state == S_ACQ || m_state == S_ERR) begin
                    m_state = S_UNL; m_good = 0;
                end else if (m_state == S_LCK) begin
                    m_state = S_ERR; m_resync = 1;
                end
            end else begin
                adv  = (k == (m_prev + 1) % N);
                good = adv || (k == m_prev);
                m_ill = 0; m_serr = good ? 0 : 1; m_idx = k; m_valid = 1; m_prev = k;
                case (m_state)
                    S_UNL: begin m_state = S_ACQ; m_good = 0; end
                    S_ACQ: begin
                        if (!good) begin
                            m_state = S_UNL; m_good = 0;
                        end else if (adv) begin
                            m_good++;
                            if (m_good == LOCK_CNT) m_state = S_LCK;
                        end
                    end
                    S_LCK: if (!good) begin m_state = S_ERR; m_resync = 1; end
                    default: begin m_state = S_UNL; m_good = 0; end
                endcase
            end
            if ((m_ill != 0 || m_serr != 0) && m_err < 255) m_err++;
        end
    endtask

    task automatic check_all();
        logic [31:0] oh;
        oh = (m_valid != 0) ? (32'd1 << m_idx) : 32'd0;
        chk("phase_idx", phase_idx, m_idx);
        chk("phase_onehot", phase_onehot, oh);
        chk("phase_valid", phase_valid, m_valid);
        chk("illegal", illegal, m_ill);
        chk("step_err", step_err, m_serr);
        chk("locked", locked, (m_state == S_LCK) ? 1 : 0);
        chk("resync_req", resync_req, m_resync);
        chk("err_cnt", err_cnt, exp_err());
    endtask

    // One clock: drive, take the edge, advance the model, sample 1 ns later
    task automatic cyc(input int q, input bit v, input bit r);
        rst = r; q_valid = v; q_in = W'(q);
        @(posedge clk);
        model_step(q, v, r);
        #1;
        check_all();
    endtask

    function automatic int rand_illegal();
        int q;
        do q = int'($urandom_range(0, (1 << W) - 1)); while (ref_lookup(q) >= 0);
        return q;
    endfunction

    initial begin
        int cur, sel;

        // 1: reset, clean ring sequence, lock after the 4th advance, wrap
        cyc(0, 1'b0, 1'b1);
        cyc(0, 1'b0, 1'b1);
        chk("t1_reset_idx", phase_idx, 0);
        chk("t1_reset_locked", locked, 0);
        chk("t1_reset_valid", phase_valid, 0);
        for (int k = 0; k < N; k++) begin
            cyc(ref_code(k), 1'b1, 1'b0);
            if (k == 3) chk("t1_not_yet_locked", locked, 0);
            if (k == 4) chk("t1_locked", locked, 1);
        end
        cyc(ref_code(0), 1'b1, 1'b0);
        chk("t1_wrap_step_err", step_err, 0);
        chk("t1_wrap_idx", phase_idx, 0);
        cyc(ref_code(1), 1'b1, 1'b0);
        cyc(ref_code(2), 1'b1, 1'b0);

        // 2: illegal code while locked
        cyc(5'b01010, 1'b1, 1'b0);
        chk("t2_illegal", illegal, 1);
        chk("t2_resync", resync_req, 1);
        chk("t2_locked", locked, 0);
        chk("t2_onehot", phase_onehot, 0);
        chk("t2_idx_hold", phase_idx, 2);
`ifdef JOHNSON_DEC_ERR_COUNT_EN
        chk("t2_err_cnt", err_cnt, 1);
`endif
        cyc(ref_code(2), 1'b1, 1'b0);
        chk("t2_error_resync_low", resync_req, 0);
        cyc(ref_code(3), 1'b1, 1'b0);

        // 3: legal but non-adjacent code while locked at phase 3
        cyc(0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(ref_code((9 + i) % N), 1'b1, 1'b0);
        chk("t3_locked_at3", locked, 1);
        cyc(5'b11110, 1'b1, 1'b0);
        chk("t3_step_err", step_err, 1);
        chk("t3_illegal", illegal, 0);
        chk("t3_idx", phase_idx, 6);
        chk("t3_resync", resync_req, 1);

        // 4: q_valid gap in ACQUIRE, then a hold, then two more advances
        cyc(0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cyc(ref_code(k), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(int'($urandom_range(0, 31)), 1'b0, 1'b0);
            chk("t4_frozen_idx", phase_idx, 2);
        end
        cyc(ref_code(2), 1'b1, 1'b0);
        cyc(ref_code(3), 1'b1, 1'b0);
        chk("t4_not_yet_locked", locked, 0);
        cyc(ref_code(4), 1'b1, 1'b0);
        chk("t4_locked", locked, 1);
        chk("t4_no_err", err_cnt, 0);

        // 5: reset while locked at phase 7
        for (int k = 5; k < 8; k++) cyc(ref_code(k), 1'b1, 1'b0);
        chk("t5_idx7", phase_idx, 7);
        cyc(ref_code(8), 1'b1, 1'b1);
        chk("t5_idx", phase_idx, 0);
        chk("t5_onehot", phase_onehot, 0);
        chk("t5_locked", locked, 0);
        chk("t5_err_cnt", err_cnt, 0);

        // 6: 300 illegal samples saturate (or keep at zero) the error count
        for (int i = 0; i < 300; i++) cyc(rand_illegal(), 1'b1, 1'b0);
`ifdef JOHNSON_DEC_ERR_COUNT_EN
        chk("t6_err_sat", err_cnt, 255);
`else
        chk("t6_err_zero", err_cnt, 0);
`endif

        // 7: random walk with holds, jumps, illegal codes, gaps and resets
        cyc(0, 1'b0, 1'b1);
        cur = 0;
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                cyc(0, 1'b1, 1'b1);
                cur = 0;
            end else if (sel < 12) begin
                cyc(int'($urandom_range(0, 31)), 1'b0, 1'b0);
            end else if (sel < 17) begin
                cyc(rand_illegal(), 1'b1, 1'b0);
            end else if (sel < 22) begin
                cur = int'($urandom_range(0, N - 1));
                cyc(ref_code(cur), 1'b1, 1'b0);
            end else if (sel < 45) begin
                cyc(ref_code(cur), 1'b1, 1'b0);
            end else begin
                cur = (cur + 1) % N;
                cyc(ref_code(cur), 1'b1, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
